uart_mem_loader: RTL and testbench

- Inverse of the ROM-dump path: receives a framed byte stream from the buart receive side and writes it into the 512x8 program memory through its write port.
- Answers each frame with a one-byte status over the buart transmit side.
- A 'G' command emits a start pulse so the consumer (the ROM-dump CPU) can begin executing the freshly loaded image.

---
 rtl/uart_mem_loader.sv | 141 ++++++++++++++
 tb/tb_uart_mem_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: loads framed buart bytes into program memory and answers with a status byte
module uart_mem_loader #(
  parameter int ADDR_W = 9,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_rd,
  input  logic              tx_busy,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              go,
  output logic              loading
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHK, S_RESP_WAIT, S_RESP_END
  } state_t;
  state_t r_state, w_state;
  logic              r_rx_rd, w_rx_rd, r_tx_wr, w_tx_wr, r_we, w_we, r_go, w_go, w_acc;
  logic [7:0]        r_tx_data, w_tx_data, r_wdata, w_wdata, r_len, w_len, r_cnt, w_cnt, r_sum, w_sum;
  logic [ADDR_W-1:0] r_waddr, w_waddr, r_addr, w_addr;
`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0]     r_to, w_to;
  logic              w_counting;
`endif
  always_comb begin
    w_state   = r_state;
    w_tx_wr   = 1'b0;
    w_tx_data = r_tx_data;
    w_we      = 1'b0;
    w_waddr   = r_waddr;
    w_wdata   = r_wdata;
    w_go      = 1'b0;
    w_addr    = r_addr;
    w_len     = r_len;
    w_cnt     = r_cnt;
    w_sum     = r_sum;
    w_acc     = rx_valid && !r_rx_rd && r_state != S_RESP_WAIT && r_state != S_RESP_END;
    w_rx_rd   = w_acc;
    if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          w_go      = rx_data == 8'h47;
          w_tx_data = w_go ? 8'h4B : r_tx_data;
          w_state   = rx_data == 8'h4C ? S_ADDR_HI : w_go ? S_RESP_WAIT : S_IDLE;
          w_sum     = 8'h00;
          w_cnt     = 8'h00;
        end
        S_ADDR_HI: begin
          w_addr  = ADDR_W'({rx_data, 8'h00});
          w_state = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          w_addr  = (r_addr & ~ADDR_W'(8'hFF)) | ADDR_W'(rx_data);
          w_state = S_LEN;
        end
        S_LEN: begin
          w_len   = rx_data;
          w_state = S_DATA;
        end
        S_DATA: begin
          w_we    = 1'b1;
          w_waddr = r_addr;
          w_wdata = rx_data;
          w_addr  = r_addr + 1'b1;
          w_sum   = r_sum + rx_data;
          w_cnt   = r_cnt + 8'd1;
          w_state = w_cnt == r_len ? S_CHK : S_DATA;
        end
        S_CHK: begin
          w_tx_data = 8'(r_sum + rx_data) == 8'h00 ? 8'h4B : 8'h45;
          w_state   = S_RESP_WAIT;
        end
        default: ;
      endcase
    end
    if (r_state == S_RESP_WAIT && !tx_busy) begin
      w_tx_wr = 1'b1;
      w_state = S_RESP_END;
    end
    if (r_state == S_RESP_END)
      w_state = S_IDLE;
`ifdef LOADER_TIMEOUT_EN
    w_counting = r_state inside {S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHK};
    w_to       = (w_acc || !w_counting) ? '0 : r_to + 1'b1;
    if (!w_acc && w_counting && r_to == TW'(TIMEOUT_CYCLES - 1)) begin
      w_tx_data = 8'h54;
      w_state   = S_RESP_WAIT;
    end
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rx_rd   <= 1'b0;
      r_tx_wr   <= 1'b0;
      r_tx_data <= 8'h00;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= 8'h00;
      r_go      <= 1'b0;
      r_addr    <= '0;
      r_len     <= 8'h00;
      r_cnt     <= 8'h00;
      r_sum     <= 8'h00;
`ifdef LOADER_TIMEOUT_EN
      r_to      <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_rx_rd   <= w_rx_rd;
      r_tx_wr   <= w_tx_wr;
      r_tx_data <= w_tx_data;
      r_we      <= w_we;
      r_waddr   <= w_waddr;
      r_wdata   <= w_wdata;
      r_go      <= w_go;
      r_addr    <= w_addr;
      r_len     <= w_len;
      r_cnt     <= w_cnt;
      r_sum     <= w_sum;
`ifdef LOADER_TIMEOUT_EN
      r_to      <= w_to;
`endif
    end
  end
  assign rx_rd     = r_rx_rd;
  assign tx_wr     = r_tx_wr;
  assign tx_data   = r_tx_data;
  assign mem_we    = r_we;
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wdata;
  assign go        = r_go;
  assign loading   = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: frame-level model of the loader checked against the DUT every cycle, plus literal pins
module tb_uart_mem_loader;
  logic       clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rd, tx_wr, mem_we, go, loading;
  logic [7:0] tx_data, mem_wdata;
  logic [8:0] mem_waddr;

  uart_mem_loader #(.ADDR_W(9), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .go(go), .loading(loading)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, go_cnt = 0, go_exp = 0;
  logic [16:0] exp_w[$], obs_w[$];
  logic [7:0]  exp_tx[$], obs_tx[$], fr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("we_go_exclusive", {31'b0, mem_we & go}, 32'h0);
      if (mem_we) begin
        obs_w.push_back({mem_waddr, mem_wdata});
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %0h expected none", {mem_waddr, mem_wdata});
        end else chk("write", {15'b0, mem_waddr, mem_wdata}, {15'b0, exp_w.pop_front()});
      end
      if (tx_wr) begin
        obs_tx.push_back(tx_data);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx: got %0h expected none", tx_data);
        end else chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
      end
      if (go) go_cnt++;
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_rd !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL rx_accept_timeout: byte %0h never consumed", b);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (loading && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, loading}, 32'h0);
  endtask

  task automatic run_frame();
    logic [8:0] a;
    logic [7:0] s;
    int n;
    if (fr[0] == 8'h4C) begin
      a = {fr[1][0], fr[2]};
      n = fr[3] == 8'h00 ? 256 : int'(fr[3]);
      s = 8'h00;
      for (int i = 0; i < n; i++) begin
        exp_w.push_back({9'(a + 9'(i)), fr[4 + i]});
        s = s + fr[4 + i];
      end
      exp_tx.push_back(8'(s + fr[4 + n]) == 8'h00 ? 8'h4B : 8'h45);
    end else if (fr[0] == 8'h47) begin
      exp_tx.push_back(8'h4B);
      go_exp++;
    end
    foreach (fr[i]) send(fr[i]);
    wait_idle("frame_back_to_idle");
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {8'b0, loading, rx_rd, tx_wr, mem_we, go, tx_data, mem_waddr}, 32'h0);
    chk({name, "_wdata"}, {24'b0, mem_wdata}, 32'h0);
  endtask

  initial begin
    #1 chk_all_zero("reset_outputs");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    fr = '{8'h4C, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    run_frame();
    chk("lit_w0", {15'b0, obs_w[0]}, {15'b0, 9'h010, 8'h11});
    chk("lit_w1", {15'b0, obs_w[1]}, {15'b0, 9'h011, 8'h22});
    chk("lit_w2", {15'b0, obs_w[2]}, {15'b0, 9'h012, 8'h33});
    chk("lit_tx_ok", {24'b0, obs_tx[0]}, 32'h4B);

    fr = '{8'h4C, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9B};
    run_frame();
    chk("lit_tx_err", {24'b0, obs_tx[1]}, 32'h45);
    chk("lit_w_count", obs_w.size(), 32'd6);

    fr = '{8'h4C, 8'h01, 8'hFF, 8'h02, 8'hAA, 8'h55, 8'h01};
    run_frame();
    chk("lit_wrap_hi", {15'b0, obs_w[6]}, {15'b0, 9'h1FF, 8'hAA});
    chk("lit_wrap_lo", {15'b0, obs_w[7]}, {15'b0, 9'h000, 8'h55});
    chk("lit_tx_wrap", {24'b0, obs_tx[2]}, 32'h4B);

    tx_busy = 1'b1;
    exp_tx.push_back(8'h4B);
    go_exp++;
    send(8'h47);
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("busy_no_tx", {31'b0, tx_wr}, 32'h0);
      chk("pending_not_consumed", {31'b0, rx_rd}, 32'h0);
    end
    chk("go_once", go_cnt, 32'd1);
    @(posedge clk); #1;
    tx_busy = 1'b0;
    begin
      int n = 0;
      while (rx_rd !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("pending_consumed_in_idle", {31'b0, rx_rd}, 32'h1);
    chk("lit_tx_go", {24'b0, obs_tx[3]}, 32'h4B);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    send(8'h00);
    repeat (5) @(negedge clk);
    chk("ignored_stays_idle", {31'b0, loading}, 32'h0);
    chk("ignored_no_writes", obs_w.size(), 32'd8);

    exp_w.push_back({9'h020, 8'h01});
    fr = '{8'h4C, 8'h00, 8'h20, 8'h05, 8'h01};
    foreach (fr[i]) send(fr[i]);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset_mid_frame");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    fr = '{8'h4C, 8'h00, 8'h00, 8'h01, 8'h7E, 8'h82};
    run_frame();
    chk("lit_after_reset_w", {15'b0, obs_w[obs_w.size() - 1]}, {15'b0, 9'h000, 8'h7E});

`ifdef LOADER_TIMEOUT_EN
    exp_tx.push_back(8'h54);
    fr = '{8'h4C, 8'h00, 8'h05};
    foreach (fr[i]) send(fr[i]);
    wait_idle("timeout_back_to_idle");
    chk("lit_tx_timeout", {24'b0, obs_tx[obs_tx.size() - 1]}, 32'h54);
    fr = '{8'h4C, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    run_frame();
`endif

    repeat (5) @(negedge clk);
    chk("writes_drained", exp_w.size(), 32'd0);
    chk("tx_drained", exp_tx.size(), 32'd0);
    chk("go_total", go_cnt, go_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
